bin_to_bcd_converter: RTL



---
 rtl/bin_to_bcd_converter_if.sv | 23 ++
 rtl/bin_to_bcd_converter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_converter_if.sv
// Handshake bundle between a binary producer and the double-dabble BCD converter.
// The master drives start/bin_in; the converter (slave) returns status and result.
interface bin_to_bcd_converter_if #(
  parameter int N = 2,
  parameter int W = 7
);
  logic           start;
  logic [W-1:0]   bin_in;
  logic           busy;
  logic           done;
  logic [4*N-1:0] bcd_out;
  logic           overflow;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, overflow
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, overflow
  );
endinterface

// File: rtl/bin_to_bcd_converter.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one shift per input bit.
// Results, overflow flag and busy/done are all registered.
module bin_to_bcd_converter #(
  parameter int N = 2,
  parameter int W = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  bin_to_bcd_converter_if.slave bus
);

  // Decimal digits needed for 2^w - 1, so the scratch never loses high digits.
  function automatic int dec_digits(input int w);
    longint unsigned v;
    int              d;
    v = (64'd1 << w) - 64'd1;
    d = 1;
    while (v >= 64'd10) begin
      v = v / 64'd10;
      d = d + 1;
    end
    return d;
  endfunction

  function automatic logic [63:0] max_decimal(input int n);
    logic [63:0] p;
    p = 64'd1;
    if (n >= 10) begin
      p = {64{1'b1}};
    end else begin
      for (int i = 0; i < n; i++) begin
        p = p * 64'd10;
      end
      p = p - 64'd1;
    end
    return p;
  endfunction

  localparam int          SD    = (dec_digits(W) > N) ? dec_digits(W) : N;
  localparam int          SB    = 4 * SD;
  localparam int          CW    = $clog2(W + 1);
  localparam logic [63:0] LIMIT = max_decimal(N);

  // Each digit >= 5 is corrected by +3 before the shift so it carries properly.
  function automatic logic [SB-1:0] add3_digits(input logic [SB-1:0] b);
    logic [SB-1:0] r;
    r = b;
    for (int k = 0; k < SD; k++) begin
      if (b[4*k +: 4] >= 4'd5) begin
        r[4*k +: 4] = b[4*k +: 4] + 4'd3;
      end else begin
        r[4*k +: 4] = b[4*k +: 4];
      end
    end
    return r;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_FINISH = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [SB+W-1:0] scratch_q, scratch_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_nxt_q, ovf_nxt_d;
  logic [4*N-1:0]  bcd_q, bcd_d;
  logic            ovf_q, ovf_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic [SB-1:0]   adj_s;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (cnt_q == CW'(1)) begin
          state_d = S_FINISH;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    ovf_nxt_d = ovf_nxt_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    adj_s     = add3_digits(scratch_q[W +: SB]);
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          scratch_d = {{SB{1'b0}}, bus.bin_in};
          cnt_d     = CW'(W);
          ovf_nxt_d = (64'(bus.bin_in) > LIMIT);
        end else begin
          scratch_d = scratch_q;
        end
      end
      S_SHIFT: begin
        scratch_d = {adj_s, scratch_q[W-1:0]} << 1;
        cnt_d     = cnt_q - CW'(1);
      end
      S_FINISH: begin
        bcd_d  = scratch_q[W +: 4*N];
        ovf_d  = ovf_nxt_q;
        done_d = 1'b1;
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scratch_q <= '0;
      cnt_q     <= '0;
      ovf_nxt_q <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      ovf_nxt_q <= ovf_nxt_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.bcd_out  = bcd_q;
  assign bus.overflow = ovf_q;

endmodule
